uart_tx: RTL



---
 rtl/uart_tx_if.sv | 22 ++
 rtl/uart_tx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Byte handshake between a message source and the UART transmitter.
// A byte moves on any posedge where i_req and o_cts are both high.
interface uart_tx_if;
  logic [7:0] i_data;
  logic       i_req;
  logic       o_cts;
  logic       o_idle;

  modport master (
    output i_data,
    output i_req,
    input  o_cts,
    input  o_idle
  );

  modport slave (
    input  i_data,
    input  i_req,
    output o_cts,
    output o_idle
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter, LSB first, with a one-byte holding register
// and a line-quiet indicator for framing bursts of messages.
module uart_tx #(
  parameter int CLKS_PER_BIT = 3,
  parameter int STOP_BITS    = 1,
  parameter int IDLE_BITS    = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus,
  output logic     o_serial
);

  localparam int IDLE_MAX = IDLE_BITS * CLKS_PER_BIT;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int IW       = $clog2(IDLE_MAX + 1);

  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDLE_SAT  = IW'(IDLE_MAX);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          full_q, full_d;
  logic          cts_q, cts_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic          idle_q, idle_d;
  logic          ser_q, ser_d;

  logic accept;
  logic bit_end;
  logic last_stop;
  logic load;

  assign accept    = bus.i_req & cts_q;
  assign bit_end   = (cyc_q == CYC_LAST);
  assign last_stop = (state_q == S_STOP) & bit_end
                   & (stop_q == STOP_LAST);
  assign load      = full_q & ((state_q == S_IDLE) | last_stop);

  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (accept) begin
      hold_d = bus.i_data;
      full_d = 1'b1;
    end else if (load) begin
      full_d = 1'b0;
    end
  end

  assign cts_d = ~full_d;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    ser_d   = ser_q;
    unique case (state_q)
      S_IDLE: begin
        ser_d = 1'b1;
        if (load) begin
          state_d = S_START;
          cyc_d   = '0;
          shift_d = hold_q;
          ser_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cyc_d   = '0;
          bit_d   = 3'd0;
          ser_d   = shift_q[0];
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            stop_d  = 1'b0;
            ser_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            ser_d   = shift_q[1];
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cyc_d = '0;
          if (stop_q == STOP_LAST) begin
            // back-to-back frames: next start bit with no gap cycle
            if (load) begin
              state_d = S_START;
              shift_d = hold_q;
              ser_d   = 1'b0;
            end else begin
              state_d = S_IDLE;
              ser_d   = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ser_d   = 1'b1;
      end
    endcase
  end

  always_comb begin
    icnt_d = icnt_q;
    if (accept) begin
      icnt_d = '0;
    end else if ((state_q == S_IDLE) && !full_q
                 && (icnt_q != IDLE_SAT)) begin
      icnt_d = icnt_q + 1'b1;
    end
  end

  assign idle_d = (icnt_d == IDLE_SAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= 3'd0;
      stop_q  <= 1'b0;
      shift_q <= 8'h00;
      hold_q  <= 8'h00;
      full_q  <= 1'b0;
      cts_q   <= 1'b1;
      icnt_q  <= '0;
      idle_q  <= 1'b0;
      ser_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      cts_q   <= cts_d;
      icnt_q  <= icnt_d;
      idle_q  <= idle_d;
      ser_q   <= ser_d;
    end
  end

  assign bus.o_cts  = cts_q;
  assign bus.o_idle = idle_q;
  assign o_serial   = ser_q;

endmodule
